// File: rtl/mult_q_pipe.sv
// mult_q_pipe: three-stage signed fixed-point multiplier, Q(WIDTH-FBITS).FBITS,
// valid/ready stream, selectable round-half-up or floor, optional saturation.
// S1 registers operands, S2 the full product, S3 the scaled/range-checked result.
module mult_q_pipe #(
    parameter int WIDTH  = 32,
    parameter int FBITS  = 27,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             round_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);
    localparam int PW = 2 * WIDTH;

    logic [3:1]              vld_pipe;
    logic                    stall;
    logic signed [WIDTH-1:0] a_q, b_q;
    logic                    rnd1, rnd2;
    logic signed [PW-1:0]    p_q;
    logic signed [PW:0]      ext, rnd_add, sum, r;
    logic [PW-WIDTH+1:0]     hi;
    logic                    ovf_c;
    logic [WIDTH-1:0]        y_c;

    // one global stall: a held result freezes every stage
    assign out_valid = vld_pipe[3];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !rst && !stall;

    // stage valid shift register; bubbles travel like data
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (!stall)
            vld_pipe <= {vld_pipe[2:1], in_valid};
    end

    // S1 operand capture and S2 full-width product (data needs no reset)
    always_ff @(posedge clk) begin
        if (!stall) begin
            a_q  <= a;
            b_q  <= b;
            rnd1 <= round_en;
            p_q  <= PW'(a_q) * PW'(b_q);
            rnd2 <= rnd1;
        end
    end

    // scale product back to Q format: optional half-LSB add, then floor shift;
    // one guard bit keeps min*min plus the rounding term from wrapping
    always_comb begin
        ext     = (PW+1)'(p_q);
        rnd_add = '0;
        if (rnd2)
            rnd_add[FBITS-1] = 1'b1;
        sum   = ext + rnd_add;
        r     = sum >>> FBITS;
        // in range only if everything above the result sign bit is sign copies
        hi    = r[PW:WIDTH-1];
        ovf_c = !((&hi) || (hi == '0));
        y_c   = r[WIDTH-1:0];
        if (ovf_c && SAT_EN)
            y_c = r[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // S3 result register; only valid slots load so y/ovf hold across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= '0;
            ovf <= 1'b0;
        end else if (!stall && vld_pipe[2]) begin
            y   <= y_c;
            ovf <= ovf_c;
        end
    end

endmodule

// File: tb/tb_mult_q_pipe.sv
// Bench for mult_q_pipe: two instances (saturating and wrapping) share stimulus;
// expected results are queued as operands are accepted and popped on output transfer.
module tb_mult_q_pipe;
    localparam int W  = 32;
    localparam int FB = 27;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          round_en = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  a = '0, b = '0;
    logic          in_ready, out_valid, ovf;
    logic [W-1:0]  y;
    logic          in_ready_w, out_valid_w, ovf_w;
    logic [W-1:0]  y_w;

    typedef struct {
        logic [W-1:0] ys;
        logic         ov;
        logic [W-1:0] yw;
        int           cyc;
    } exp_t;

    exp_t   sbq[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    bit     lat_chk = 1'b1;
    bit     rnd_bp = 1'b0;
    bit     prev_stall = 1'b0;
    logic [W-1:0] prev_y, prev_yw;
    logic   prev_ovf;

    mult_q_pipe #(.WIDTH(W), .FBITS(FB), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_en(round_en), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .ovf(ovf));

    mult_q_pipe #(.WIDTH(W), .FBITS(FB), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .round_en(round_en), .out_valid(out_valid_w),
        .out_ready(out_ready), .y(y_w), .ovf(ovf_w));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // reference arithmetic on 64-bit integers with explicit range compare
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic rv, output exp_t e);
        longint p, rr;
        p = longint'($signed(av)) * longint'($signed(bv));
        if (rv) p = p + (longint'(1) <<< (FB-1));
        rr = p >>> FB;
        e.ov = (rr > 64'sd2147483647) || (rr < -64'sd2147483648);
        e.yw = rr[W-1:0];
        e.ys = e.ov ? ((rr < 0) ? 32'h80000000 : 32'h7FFFFFFF) : rr[W-1:0];
        e.cyc = 0;
    endfunction

    // output monitor: scoreboard pop, latency, stall hold, instance agreement
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || y !== prev_y || ovf !== prev_ovf || y_w !== prev_yw) begin
                    failures++;
                    $display("FAIL stall_hold: got vld=%b y=%h ovf=%b yw=%h, need vld=1 y=%h ovf=%b yw=%h",
                             out_valid, y, ovf, y_w, prev_y, prev_ovf, prev_yw);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_valid_w !== out_valid || in_ready_w !== in_ready) begin
                    failures++;
                    $display("FAIL inst_sync: vld_w=%b rdy_w=%b vs vld=%b rdy=%b",
                             out_valid_w, in_ready_w, out_valid, in_ready);
                end
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_out: y=%h ovf=%b with nothing outstanding", y, ovf);
                end else begin
                    e = sbq.pop_front();
                    if (y !== e.ys || ovf !== e.ov || y_w !== e.yw || ovf_w !== e.ov) begin
                        failures++;
                        $display("FAIL result: got y=%h ovf=%b yw=%h ovfw=%b, need y=%h ovf=%b yw=%h",
                                 y, ovf, y_w, ovf_w, e.ys, e.ov, e.yw);
                    end
                    if (lat_chk && (cyc - e.cyc) != 3) begin
                        failures++;
                        $display("FAIL latency: got %0d cycles, need 3", cyc - e.cyc);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            prev_yw    = y_w;
            prev_ovf   = ovf;
        end
    end

    // drive one operand pair (called at posedge+1), push its expectation on accept
    task automatic send_e(input logic [W-1:0] av, input logic [W-1:0] bv, input logic rv,
                          input exp_t e_in);
        exp_t e;
        int n;
        e = e_in;
        in_valid = 1'b1; a = av; b = bv; round_en = rv;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=0, need 1 within 200 cycles");
        end else begin
            e.cyc = cyc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic rv,
                        input logic [W-1:0] ys, input logic ov, input logic [W-1:0] yw);
        exp_t e;
        e.ys = ys; e.ov = ov; e.yw = yw; e.cyc = 0;
        send_e(av, bv, rv, e);
    endtask

    task automatic send_m(input logic [W-1:0] av, input logic [W-1:0] bv, input logic rv);
        exp_t e;
        model(av, bv, rv, e);
        send_e(av, bv, rv, e);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: %0d results outstanding, need 0", tag, sbq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== '0 || ovf !== 1'b0 || in_ready !== 1'b0 ||
            out_valid_w !== 1'b0 || y_w !== '0 || in_ready_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: vld=%b y=%h ovf=%b rdy=%b, need 0 0 0 0",
                     out_valid, y, ovf, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b need 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        lat_chk = 1'b1;
        send(32'h0C000000, 32'h10000000, 1'b0, 32'h18000000, 1'b0, 32'h18000000);
        send(32'hF6000000, 32'h20000000, 1'b0, 32'hD8000000, 1'b0, 32'hD8000000);
        drain("basic");
    endtask

    task automatic test_rounding();
        send(32'h00000001, 32'h04000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000);
        send(32'h00000001, 32'h04000000, 1'b1, 32'h00000001, 1'b0, 32'h00000001);
        send(32'hFFFFFFFF, 32'h04000000, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF);
        send(32'hFFFFFFFF, 32'h04000000, 1'b1, 32'h00000000, 1'b0, 32'h00000000);
        drain("rounding");
    endtask

    task automatic test_saturation();
        // 4*4: saturates to max, wraps to 0x80000000
        send(32'h20000000, 32'h20000000, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h80000000);
        // -4*4 = -16 is exactly the most negative value
        send(32'hE0000000, 32'h20000000, 1'b0, 32'h80000000, 1'b0, 32'h80000000);
        // min*min: 2^35 after scaling, low bits wrap to 0
        send(32'h80000000, 32'h80000000, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h00000000);
        send(32'h80000000, 32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1, 32'h00000000);
        // large negative overflow saturates to min
        send(32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h80000000, 1'b1, 32'h00000010);
        drain("saturation");
    endtask

    task automatic test_back_to_back();
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++)
            send_m($urandom(), $urandom(), 1'($urandom_range(0, 1)));
        drain("b2b");
    endtask

    task automatic test_backpressure();
        lat_chk = 1'b0;
        rnd_bp = 1'b1;
        for (int i = 0; i < 8; i++)
            send_m($urandom() >> $urandom_range(0, 8), $urandom(), 1'($urandom_range(0, 1)));
        drain("backpressure");
        rnd_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(2);
        lat_chk = 1'b1;
    endtask

    task automatic test_bubbles();
        lat_chk = 1'b1;
        send_m(32'h0C000000, 32'h10000000, 1'b0);
        idle(1);
        send_m(32'hF6000000, 32'h20000000, 1'b1);
        send_m(32'h12345678, 32'hFEDCBA98, 1'b1);
        idle(1);
        drain("bubbles");
    endtask

    task automatic test_reset_mid();
        lat_chk = 1'b1;
        send_m(32'h0C000000, 32'h10000000, 1'b0);
        send_m(32'h20000000, 32'h20000000, 1'b0);
        send_m(32'hF6000000, 32'h20000000, 1'b0);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || in_ready_w !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_reset: got %b need 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== '0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: vld=%b y=%h ovf=%b, need 0 0 0", out_valid, y, ovf);
        end
        rst = 1'b0;
        idle(6);
        send_m(32'h0C000000, 32'h20000000, 1'b0);
        drain("after_reset");
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
